// File: rtl/serial_chk_sched.sv
// serial_chk_sched: round-robin scheduler that shares one serial pattern checker among NREQ requesters.
module serial_chk_sched #(
  parameter int WIDTH = 16,
  parameter int NREQ = 2,
  parameter int IDW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  ser_a,
  output logic                  chk_clr,
  input  logic                  chk_s,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_flag,
  input  logic                  rsp_ready,
  output logic                  busy
);
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, SHIFT = 3'd2, SETTLE = 3'd3, RESP = 3'd4;
  localparam int CW = $clog2(WIDTH);
  logic [2:0] state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  logic [IDW-1:0] last_grant, gnt;
  logic found;
  always_comb begin
    gnt = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++)
      for (int i = 0; i < NREQ; i++)
        if (!found && req_valid[i] && i == (int'(last_grant) + k) % NREQ) begin
          gnt = IDW'(i);
          found = 1'b1;
        end
  end
  assign req_ready = (state == IDLE && found && !rst) ? NREQ'(1) << gnt : '0;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  // ser_a and chk_clr come straight from flops so the checker sees clean levels
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      last_grant <= IDW'(NREQ - 1);
      ser_a <= 1'b0;
      chk_clr <= 1'b0;
      rsp_id <= '0;
      rsp_flag <= 1'b0;
    end else begin
      chk_clr <= state == IDLE && found;
      case (state)
        IDLE: if (found) begin
          sr <= req_data[int'(gnt)*WIDTH +: WIDTH];
          rsp_id <= gnt;
          last_grant <= gnt;
          state <= CLEAR;
        end
        CLEAR: begin
          cnt <= CW'(WIDTH - 1);
          ser_a <= sr[WIDTH-1];
          sr <= sr << 1;
          state <= SHIFT;
        end
        SHIFT: begin
          ser_a <= (cnt != '0) & sr[WIDTH-1];
          sr <= sr << 1;
          cnt <= cnt - 1'b1;
          state <= (cnt == '0) ? SETTLE : SHIFT;
        end
        SETTLE: begin
          rsp_flag <= chk_s;
          state <= RESP;
        end
        RESP: state <= rsp_ready ? IDLE : RESP;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_chk_sched.sv
// tb_serial_chk_sched: randomized and directed scoreboard bench with a behavioural "101" checker.
module tb_serial_chk_sched;
  localparam int W = 16, N = 2, IDW = 3;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_data;
  logic ser_a, chk_clr, chk_s, rsp_valid, rsp_flag, rsp_ready, busy;
  logic [IDW-1:0] rsp_id;
  typedef struct packed {logic [IDW-1:0] id; logic flag;} exp_t;
  exp_t q[$];
  exp_t cur, e;
  int n_cmp = 0, n_bad = 0, cyc = 0, n_rsp = 0, last_acc = -1, g, t = 0, m_last = N - 1, n0;
  bit gap_en = 0, m_busy = 0;
  logic [W-1:0] fr;
  logic [2:0] h = '0;
  logic m_s = 0, frc_en = 0, frc_v = 0;

  serial_chk_sched #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ser_a(ser_a), .chk_clr(chk_clr), .chk_s(chk_s), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_flag(rsp_flag), .rsp_ready(rsp_ready), .busy(busy));

  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // external checker: s goes high when the last three serial bits were 1,0,1
  assign chk_s = frc_en ? frc_v : m_s;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (chk_clr) begin
      h <= '0;
      m_s <= 1'b0;
    end else begin
      h <= {h[1:0], ser_a};
      m_s <= ({h[1:0], ser_a} == 3'b101);
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // reference timeline: grant by rotation, then clear, WIDTH bits MSB-first, settle, response
  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0;
      m_last = N - 1;
      q.delete();
    end else if (!m_busy) begin
      g = -1;
      for (int k = 1; k <= N; k++)
        if (g < 0 && ((req_valid >> ((m_last + k) % N)) & 1) != 0) g = (m_last + k) % N;
      chk("req_ready", 64'(req_ready), g < 0 ? 64'd0 : 64'd1 << g);
      chk("idle_outputs", {busy, chk_clr, ser_a, rsp_valid}, 0);
      if (g >= 0) begin
        m_busy = 1;
        t = 0;
        m_last = g;
        fr = req_data[g*W +: W];
        cur.id = g[IDW-1:0];
        cur.flag = fr[2:0] == 3'b101;
        q.push_back(cur);
      end
    end else begin
      t++;
      chk("req_ready_busy", 64'(req_ready), 0);
      chk("timeline", {busy, chk_clr, ser_a, rsp_valid},
          {1'b1, t == 1, (t >= 2 && t <= W + 1) ? fr[W+1-t] : 1'b0, t >= W + 3});
      if (t >= W + 3) begin
        chk("rsp_hold", {rsp_id, rsp_flag}, cur);
        if (rsp_ready) m_busy = 0;
      end
    end
  end

  always @(negedge clk)
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_rsp: got rsp id %0d expected no response", rsp_id);
      end else begin
        e = q.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_flag", rsp_flag, e.flag);
      end
      if (gap_en && last_acc >= 0) chk("rsp_gap", 64'(cyc - last_acc), W + 4);
      last_acc = cyc;
      n_rsp++;
    end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic send(input int i, input logic [W-1:0] d);
    @(posedge clk);
    #1 req_valid = N'(1) << i;
    req_data[i*W +: W] = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[i]) break;
    end
    chk("send_grant", req_ready[i], 1);
    @(posedge clk);
    #1 req_valid = '0;
    req_data = {$urandom, $urandom};
  endtask

  initial begin
    req_valid = '0;
    req_data = '0;
    rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", {req_ready, ser_a, chk_clr, rsp_valid, rsp_id, rsp_flag, busy}, 0);
    rst = 0;
    send(0, 16'hA5C3);
    wait_idle();
    send(1, 16'h0000);
    wait_idle();
    send(0, 16'hFFFF);
    wait_idle();
    @(posedge clk);
    #1 gap_en = 1;
    last_acc = -1;
    n0 = n_rsp;
    req_valid = 2'b11;
    for (int i = 0; i < 200 && n_rsp < n0 + 4; i++) @(posedge clk);
    #1 req_valid = '0;
    gap_en = 0;
    chk("four_frames", n_rsp - n0 >= 4, 1);
    wait_idle();
    @(posedge clk);
    #1 rsp_ready = 0;
    req_valid = 2'b11;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("bp_reached", rsp_valid, 1);
    repeat (10) begin
      @(posedge clk);
      #1 frc_en = 1;
      frc_v = ~frc_v;
    end
    @(posedge clk);
    #1 rsp_ready = 1;
    frc_en = 0;
    @(posedge clk);
    @(negedge clk);
    chk("grant_after_resp", busy, 0);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle();
    @(posedge clk);
    #1 req_valid = 2'b11;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) break;
    end
    repeat (8) @(posedge clk);
    #3 rst = 1;
    #1 chk("async_reset", {req_ready, ser_a, chk_clr, rsp_valid, rsp_id, rsp_flag, busy}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_reset_grant", 64'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1 req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
    end
    @(posedge clk);
    #1 req_valid = '0;
    rsp_ready = 1;
    wait_idle();
    chk("queue_drained", 64'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_chk_sched.md
Name: serial_chk_sched

Overview:
- Round-robin scheduler that shares one serial bit-stream checker among NREQ requesters.
- The checker is a 1-bit-input pattern detector with a registered 1-bit result `s`.
- Per frame: accepts a parallel WIDTH-bit frame from the granted requester, clears the checker, then shifts the frame into the checker MSB-first.
- After the last bit, samples the checker result and returns it, tagged with the requester id, over a valid/ready response port.

Parameters:
- WIDTH, 16, frame length in bits (>=2).
- NREQ, 2, number of requesters (2..8).
- IDW, 3, width of the requester id field (must satisfy 2^IDW >= NREQ).

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  bit i = requester i holds a frame.
- req_data  in  NREQ*WIDTH  frame of requester i in bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot accept strobe; a frame transfers when req_valid[i] & req_ready[i].
- ser_a  out  1  serial bit to the checker `a` input.
- chk_clr  out  1  synchronous clear to the checker, one-cycle pulse.
- chk_s  in  1  checker registered result.
- rsp_valid  out  1  response available.
- rsp_id  out  IDW  index of the requester the response belongs to.
- rsp_flag  out  1  sampled checker result.
- rsp_ready  in  1  downstream accepts the response.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE, shift register=0, bit counter=0, last_grant=NREQ-1 (requester 0 wins first).
  - All outputs 0: req_ready, ser_a, chk_clr, rsp_valid, rsp_id, rsp_flag, busy.
  - A frame in flight is discarded; no response is produced for it.
- States: IDLE, CLEAR, SHIFT, SETTLE, RESP.
- IDLE:
  - req_ready is combinational: one-hot at the grant index only if some req_valid is high, else all zero.
  - Grant = first i with req_valid[i], searching from last_grant+1 modulo NREQ.
  - On a grant: load the shift register with req_data of the granted requester, latch the grant into rsp_id and last_grant, and go to CLEAR.
- CLEAR (1 cycle): chk_clr=1, ser_a=0; load the bit counter with WIDTH-1; go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - ser_a = shift register MSB, driven from a register, glitch-free.
  - Shift left by one each cycle; decrement the counter.
  - When the counter is 0 in SHIFT, go to SETTLE after that cycle.
- SETTLE (1 cycle): ser_a=0; the checker's output reflects the last bit; capture chk_s into rsp_flag at the end of the cycle; go to RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_flag are held stable until rsp_ready.
  - Return to IDLE on the cycle rsp_valid & rsp_ready.
  - No new grant is issued in that same cycle; the next grant is possible in the following cycle.
- Latency: handshake at cycle T gives chk_clr at T+1, bits at T+2..T+WIDTH+1, SETTLE at T+WIDTH+2, rsp_valid first high at T+WIDTH+3.
- Back-to-back with rsp_ready tied high: one frame per WIDTH+4 cycles.
- Fairness:
  - last_grant is updated only at a grant.
  - A requester that drops req_valid loses its turn and receives no penalty.
  - With all requesters valid, grants rotate 0,1,...,NREQ-1,0.
- Requester changes to req_data after its handshake have no effect on the frame in flight.
- chk_clr is never asserted outside CLEAR; ser_a is 0 outside SHIFT.

Test Plan:
1. Reset, then single request: req_valid=01, req_data[15:0]=16'hA5C3 -> req_ready=01 for 1 cycle. Then chk_clr pulse at T+1, ser_a serial 1010010111000011 on T+2..T+17, rsp_valid at T+19 with rsp_id=0 and rsp_flag equal to chk_s at T+18.
2. Both requesters held valid for 4 frames, rsp_ready=1 -> grants 0,1,0,1. Each rsp_valid is 20 cycles after the previous one, and rsp_id alternates 0,1,0,1.
3. Backpressure: rsp_ready=0 for 10 cycles in RESP while chk_s toggles -> rsp_valid, rsp_id and rsp_flag stay stable, busy=1, and no req_ready is asserted. rsp_ready=1 moves the block to IDLE; the next grant occurs the cycle after.
4. rst asserted at cycle T+8 mid-SHIFT -> all outputs 0 immediately (async). After release, the first grant goes to requester 0 and no response is produced for the aborted frame.
5. req_data changed at T+1 after a handshake at T -> serialized bits match the value captured at T.
6. Boundary frames 16'h0000 and 16'hFFFF: ser_a is constant 0 / constant 1 for exactly 16 cycles. ser_a=0 in CLEAR and SETTLE, and the bit count is exactly 16.
